// File: rtl/sd_req_arbiter_pkg.sv
// Shared types and constants for the SD block-port arbiter.
package sd_arb_pkg;
    typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;
    localparam int BLOCK_BYTES = 512;
    localparam int MAX_PORTS   = 4;
endpackage

// File: rtl/sd_req_arbiter_if.sv
// Host-side SD block port: command strobes, ack and the byte stream.
interface sd_host_if;
    logic [31:0] sd_lba;
    logic        sd_rd;
    logic        sd_wr;
    logic        sd_ack;
    logic [8:0]  sd_buff_addr;
    logic [7:0]  sd_buff_dout;
    logic        sd_buff_wr;
    logic [7:0]  sd_buff_din;

    modport master (
        output sd_lba, sd_rd, sd_wr, sd_buff_din,
        input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr
    );
    modport slave (
        input  sd_lba, sd_rd, sd_wr, sd_buff_din,
        output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr
    );
endinterface

// File: rtl/sd_req_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit scanning from last+1, wrapping.
module rr_pick #(
    parameter int PORTS = 2,
    parameter int IW    = $clog2(PORTS)
) (
    input  logic [PORTS-1:0] req,
    input  logic [IW-1:0]    last,
    output logic             valid,
    output logic [IW-1:0]    idx
);
    logic [IW-1:0] p;

    // Scan farthest-first so the nearest candidate after 'last' wins the overwrite.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        p     = '0;
        for (int k = PORTS; k >= 1; k--) begin
            p = IW'((int'(last) + k) % PORTS);
            if (req[p]) begin
                valid = 1'b1;
                idx   = p;
            end
        end
    end
endmodule

// File: rtl/sd_req_arbiter.sv
// Round-robin arbiter sharing one host SD block port between per-drive track loaders.
module sd_req_arbiter
    import sd_arb_pkg::*;
#(
    parameter int PORTS = 2,
    parameter int IW    = $clog2(PORTS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     req_lba      [PORTS],
    input  logic            req_rd       [PORTS],
    input  logic            req_wr       [PORTS],
    output logic            req_ack      [PORTS],
    output logic            req_buff_wr  [PORTS],
    input  logic [7:0]      req_buff_din [PORTS],
    output logic [8:0]      req_buff_addr,
    output logic [7:0]      req_buff_dout,
    sd_host_if.master       sd,
    output logic [IW-1:0]   grant,
    output logic            busy
);
    state_t           state;
    logic [IW-1:0]    last;
    logic             old_ack;
    logic [PORTS-1:0] cand;
    logic             pick_vld;
    logic [IW-1:0]    pick_idx;

    for (genvar i = 0; i < PORTS; i++) begin : g_port
        logic own;
        assign cand[i]        = req_rd[i] | req_wr[i];
        // Ownership covers REQ too, so the first ack cycle already reaches the requester.
        assign own            = (state != IDLE) && (grant == IW'(i));
        assign req_ack[i]     = own & sd.sd_ack;
        assign req_buff_wr[i] = own & sd.sd_ack & sd.sd_buff_wr;
    end

    rr_pick #(.PORTS(PORTS), .IW(IW)) u_pick (
        .req   (cand),
        .last  (last),
        .valid (pick_vld),
        .idx   (pick_idx)
    );

    assign req_buff_addr  = sd.sd_buff_addr;
    assign req_buff_dout  = sd.sd_buff_dout;
    assign sd.sd_buff_din = req_buff_din[grant];

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            sd.sd_rd  <= 1'b0;
            sd.sd_wr  <= 1'b0;
            sd.sd_lba <= '0;
            grant     <= '0;
            last      <= IW'(PORTS - 1);
            old_ack   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            old_ack <= sd.sd_ack;
            case (state)
                IDLE: begin
                    // A still-high ack (e.g. after a mid-transfer reset) blocks new grants.
                    if (!sd.sd_ack && pick_vld) begin
                        grant     <= pick_idx;
                        sd.sd_lba <= req_lba[pick_idx];
                        if (req_rd[pick_idx]) sd.sd_rd <= 1'b1;
                        else                  sd.sd_wr <= 1'b1;
                        busy  <= 1'b1;
                        state <= REQ;
                    end
                end
                REQ: begin
                    if (sd.sd_ack) begin
                        sd.sd_rd <= 1'b0;
                        sd.sd_wr <= 1'b0;
                        state    <= XFER;
                    end
                end
                XFER: begin
                    if (old_ack && !sd.sd_ack) begin
                        last  <= grant;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sd_req_arbiter.sv
// Directed bench for sd_req_arbiter with two requesters and a simple host model.
module tb_sd_req_arbiter;
    localparam int PORTS = 2;
    localparam int IW    = 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   req_lba      [PORTS];
    logic          req_rd       [PORTS];
    logic          req_wr       [PORTS];
    logic          req_ack      [PORTS];
    logic          req_buff_wr  [PORTS];
    logic [7:0]    req_buff_din [PORTS];
    logic [8:0]    req_buff_addr;
    logic [7:0]    req_buff_dout;
    logic [IW-1:0] grant;
    logic          busy;
    int            errors = 0;
    int            checks = 0;

    sd_host_if sd_bus ();

    sd_req_arbiter #(.PORTS(PORTS), .IW(IW)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_lba       (req_lba),
        .req_rd        (req_rd),
        .req_wr        (req_wr),
        .req_ack       (req_ack),
        .req_buff_wr   (req_buff_wr),
        .req_buff_din  (req_buff_din),
        .req_buff_addr (req_buff_addr),
        .req_buff_dout (req_buff_dout),
        .sd            (sd_bus),
        .grant         (grant),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        for (int i = 0; i < PORTS; i++) begin
            req_lba[i] = '0; req_rd[i] = 1'b0; req_wr[i] = 1'b0; req_buff_din[i] = '0;
        end
        sd_bus.sd_ack = 1'b0; sd_bus.sd_buff_addr = '0;
        sd_bus.sd_buff_dout = '0; sd_bus.sd_buff_wr = 1'b0;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic wait_strobe(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (sd_bus.sd_rd || sd_bus.sd_wr) begin
                ok = 1'b1;
                return;
            end
            tick();
        end
    endtask

    // Host side of one block: raise ack, stream beats, drop ack; counts routing errors.
    task automatic run_xfer(input int g, input int beats, input bit drop_rd, input bit drop_wr,
                            output int bad);
        bit exp_own;
        bad = 0;
        sd_bus.sd_ack = 1'b1;
        tick();
        if (sd_bus.sd_rd !== 1'b0 || sd_bus.sd_wr !== 1'b0) bad++;
        for (int i = 0; i < beats; i++) begin
            sd_bus.sd_buff_addr = 9'(i);
            sd_bus.sd_buff_dout = 8'(i * 3);
            sd_bus.sd_buff_wr   = (i % 2) == 1;
            if (i == 0) begin
                if (drop_rd) req_rd[g] = 1'b0;
                if (drop_wr) req_wr[g] = 1'b0;
            end
            #1;
            for (int p = 0; p < PORTS; p++) begin
                exp_own = (p == g);
                if (req_ack[p] !== exp_own) bad++;
                if (req_buff_wr[p] !== (exp_own && (i % 2) == 1)) bad++;
            end
            if (req_buff_addr !== 9'(i) || req_buff_dout !== 8'(i * 3) || busy !== 1'b1) bad++;
            tick();
        end
        sd_bus.sd_ack = 1'b0;
        sd_bus.sd_buff_wr = 1'b0;
        tick();
        if (busy !== 1'b0 || req_ack[g] !== 1'b0) bad++;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (sd_bus.sd_rd !== 1'b0) begin errors++; $display("FAIL rst_rd got %0b want 0", sd_bus.sd_rd); end
        checks++; if (sd_bus.sd_wr !== 1'b0) begin errors++; $display("FAIL rst_wr got %0b want 0", sd_bus.sd_wr); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %0b want 0", busy); end
        checks++; if (sd_bus.sd_lba !== 32'h0) begin errors++; $display("FAIL rst_lba got %0h want 0", sd_bus.sd_lba); end
        checks++; if (grant !== 1'b0) begin errors++; $display("FAIL rst_grant got %0d want 0", grant); end
        // Ack already high in IDLE: nothing may be granted or routed.
        sd_bus.sd_ack = 1'b1; sd_bus.sd_buff_wr = 1'b1; req_rd[0] = 1'b1;
        tick();
        checks++; if (sd_bus.sd_rd !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL ack_high_idle got rd=%0b busy=%0b want 0 0", sd_bus.sd_rd, busy); end
        checks++; if (req_ack[0] !== 1'b0 || req_buff_wr[0] !== 1'b0) begin errors++; $display("FAIL ack_high_route got ack=%0b bwr=%0b want 0 0", req_ack[0], req_buff_wr[0]); end
        sd_bus.sd_ack = 1'b0; sd_bus.sd_buff_wr = 1'b0; req_rd[0] = 1'b0;
    endtask

    task automatic test_single_read();
        int bad;
        do_reset();
        req_lba[0] = 32'h15; req_rd[0] = 1'b1;
        tick();
        checks++; if (sd_bus.sd_rd !== 1'b1 || sd_bus.sd_wr !== 1'b0) begin errors++; $display("FAIL rd_strobe got rd=%0b wr=%0b want 1 0", sd_bus.sd_rd, sd_bus.sd_wr); end
        checks++; if (sd_bus.sd_lba !== 32'h15) begin errors++; $display("FAIL rd_lba got %0h want 15", sd_bus.sd_lba); end
        checks++; if (busy !== 1'b1 || grant !== 1'b0) begin errors++; $display("FAIL rd_grant got busy=%0b grant=%0d want 1 0", busy, grant); end
        run_xfer(0, 512, 1'b1, 1'b0, bad);
        checks++; if (bad !== 0) begin errors++; $display("FAIL rd_xfer got %0d bad beats want 0", bad); end
    endtask

    task automatic test_contention();
        bit ok;
        int bad;
        logic [IW-1:0] exp;
        do_reset();
        req_rd[0] = 1'b1; req_rd[1] = 1'b1;
        for (int n = 0; n < 4; n++) begin
            exp = IW'(n % 2);
            wait_strobe(ok);
            checks++; if (!ok) begin errors++; $display("FAIL cont_timeout round %0d got no strobe want strobe", n); end
            checks++; if (grant !== exp) begin errors++; $display("FAIL cont_order round %0d got %0d want %0d", n, grant, exp); end
            run_xfer(int'(exp), 4, 1'b1, 1'b0, bad);
            checks++; if (bad !== 0) begin errors++; $display("FAIL cont_xfer round %0d got %0d bad want 0", n, bad); end
            req_rd[exp] = 1'b1;
        end
        req_rd[0] = 1'b0; req_rd[1] = 1'b0;
    endtask

    task automatic test_write();
        int bad;
        do_reset();
        req_lba[1] = 32'h200; req_wr[1] = 1'b1;
        req_buff_din[0] = 8'h3C; req_buff_din[1] = 8'hA5;
        tick();
        checks++; if (sd_bus.sd_wr !== 1'b1 || sd_bus.sd_rd !== 1'b0) begin errors++; $display("FAIL wr_strobe got wr=%0b rd=%0b want 1 0", sd_bus.sd_wr, sd_bus.sd_rd); end
        checks++; if (grant !== 1'b1 || sd_bus.sd_lba !== 32'h200) begin errors++; $display("FAIL wr_grant got grant=%0d lba=%0h want 1 200", grant, sd_bus.sd_lba); end
        checks++; if (sd_bus.sd_buff_din !== 8'hA5) begin errors++; $display("FAIL wr_din got %0h want a5", sd_bus.sd_buff_din); end
        req_buff_din[1] = 8'h5A;
        #1;
        checks++; if (sd_bus.sd_buff_din !== 8'h5A) begin errors++; $display("FAIL wr_din_follow got %0h want 5a", sd_bus.sd_buff_din); end
        run_xfer(1, 8, 1'b0, 1'b1, bad);
        checks++; if (bad !== 0 || sd_bus.sd_rd !== 1'b0) begin errors++; $display("FAIL wr_xfer got bad=%0d rd=%0b want 0 0", bad, sd_bus.sd_rd); end
    endtask

    task automatic test_rd_wr_both();
        bit ok;
        int bad;
        do_reset();
        req_lba[0] = 32'h40; req_rd[0] = 1'b1; req_wr[0] = 1'b1;
        tick();
        checks++; if (sd_bus.sd_rd !== 1'b1 || sd_bus.sd_wr !== 1'b0) begin errors++; $display("FAIL both_first got rd=%0b wr=%0b want 1 0", sd_bus.sd_rd, sd_bus.sd_wr); end
        run_xfer(0, 4, 1'b1, 1'b0, bad);
        wait_strobe(ok);
        checks++; if (!ok || sd_bus.sd_wr !== 1'b1 || sd_bus.sd_rd !== 1'b0 || grant !== 1'b0) begin
            errors++; $display("FAIL both_second got ok=%0b wr=%0b rd=%0b grant=%0d want 1 1 0 0", ok, sd_bus.sd_wr, sd_bus.sd_rd, grant);
        end
        run_xfer(0, 4, 1'b0, 1'b1, bad);
        checks++; if (bad !== 0) begin errors++; $display("FAIL both_xfer got %0d bad want 0", bad); end
    endtask

    task automatic test_reset_mid_xfer();
        int bad;
        do_reset();
        req_rd[0] = 1'b1;
        tick();
        sd_bus.sd_ack = 1'b1; req_rd[0] = 1'b0; req_rd[1] = 1'b1;
        tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (sd_bus.sd_rd !== 1'b0 || sd_bus.sd_wr !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL rmx_strobe got rd=%0b wr=%0b busy=%0b want 0 0 0", sd_bus.sd_rd, sd_bus.sd_wr, busy);
        end
        bad = 0;
        for (int n = 0; n < 3; n++) begin
            tick();
            if (sd_bus.sd_rd !== 1'b0 || busy !== 1'b0 || req_ack[1] !== 1'b0) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL rmx_hold got %0d grant cycles want 0", bad); end
        sd_bus.sd_ack = 1'b0;
        tick();
        checks++; if (sd_bus.sd_rd !== 1'b1 || grant !== 1'b1) begin errors++; $display("FAIL rmx_regrant got rd=%0b grant=%0d want 1 1", sd_bus.sd_rd, grant); end
        run_xfer(1, 4, 1'b1, 1'b0, bad);
        checks++; if (bad !== 0) begin errors++; $display("FAIL rmx_xfer got %0d bad want 0", bad); end
    endtask

    task automatic test_withdraw();
        int bad;
        int spur;
        do_reset();
        req_lba[0] = 32'h77; req_rd[0] = 1'b1;
        tick();
        req_rd[0] = 1'b0;
        tick();
        checks++; if (sd_bus.sd_rd !== 1'b1 || sd_bus.sd_lba !== 32'h77) begin errors++; $display("FAIL wd_hold got rd=%0b lba=%0h want 1 77", sd_bus.sd_rd, sd_bus.sd_lba); end
        run_xfer(0, 6, 1'b0, 1'b0, bad);
        checks++; if (bad !== 0) begin errors++; $display("FAIL wd_xfer got %0d bad want 0", bad); end
        spur = 0;
        for (int n = 0; n < 5; n++) begin
            if (sd_bus.sd_rd !== 1'b0 || busy !== 1'b0) spur++;
            tick();
        end
        checks++; if (spur !== 0) begin errors++; $display("FAIL wd_spurious got %0d cycles want 0", spur); end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_contention();
        test_write();
        test_rd_wr_both();
        test_reset_mid_xfer();
        test_withdraw();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sd_req_arbiter.md
# sd_req_arbiter

Round-robin arbiter that shares the single host SD block port (sd_lba / sd_rd / sd_wr / sd_ack plus the sd_buff_* byte stream) between several track-buffer controllers, one per emulated drive. It sits between the HPS-facing block-device interface and the per-drive track loaders. It serialises their 512-byte block requests, holds each grant for a full transfer, and steers the byte stream and ack back to the owning requester only.

## Interface
Parameters:
- PORTS, 2, number of requesters (2..4).
- IW, $clog2(PORTS), requester index width.

Ports (`[P]` means an unpacked array over requesters):
- clk  in  1  system clock.
- reset  in  1  reset, synchronous, active-high.
- req_lba[P]  in  32  block address per requester, sampled at grant.
- req_rd[P]  in  1  read request level, held by the requester until its req_ack is seen.
- req_wr[P]  in  1  write request level, same rule as req_rd.
- req_ack[P]  out  1  sd_ack routed to the granted port; 0 elsewhere.
- req_buff_wr[P]  out  1  sd_buff_wr gated by (grant & sd_ack).
- req_buff_din[P]  in  8  write data from each requester's buffer.
- req_buff_addr  out  9  sd_buff_addr broadcast.
- req_buff_dout  out  8  sd_buff_dout broadcast.
- sd_lba  out  32  latched lba of the granted request.
- sd_rd  out  1  host read strobe (registered).
- sd_wr  out  1  host write strobe (registered).
- sd_ack  in  1  host acknowledge, high for the whole block transfer.
- sd_buff_addr  in  9  host byte address.
- sd_buff_dout  in  8  host read data.
- sd_buff_wr  in  1  host byte write strobe.
- sd_buff_din  out  8  req_buff_din of the granted port (mux on the registered grant index).
- grant  out  IW  current or last owner index.
- busy  out  1  high in REQ and XFER.

## Operation
- State machine states: IDLE, REQ, XFER.
- IDLE
  - Precondition: sd_ack == 0. If sd_ack is high, the arbiter stays in IDLE and grants nothing.
  - Candidates: ports with req_rd | req_wr.
  - Winner: first candidate scanning from (last+1) mod PORTS upward, wrapping.
  - On a winner: latch grant, sd_lba <= req_lba[win], op <= rd (rd has priority if both are set; wr stays pending), assert sd_rd or sd_wr, go to REQ.
- REQ
  - Hold sd_rd/sd_wr and sd_lba.
  - On sd_ack == 1: clear sd_rd/sd_wr and go to XFER.
  - Requester lines are ignored while in REQ.
- XFER
  - req_ack[grant] = sd_ack.
  - req_buff_wr[grant] = sd_buff_wr & sd_ack.
  - On the sd_ack falling edge (registered old_ack == 1, sd_ack == 0): last <= grant, go to IDLE.
- Request withdrawal: if a requester drops its line while in REQ, the transfer still completes. The host contract does not allow cancelling.
- Ungranted ports see req_ack == 0 and req_buff_wr == 0 at all times.

## Timing
- Reset values:
  - sd_rd = 0, sd_wr = 0, busy = 0, sd_lba = 0.
  - grant = 0, last = PORTS-1, so port 0 wins first.
  - State IDLE. req_ack / req_buff_wr are combinational from the grant and the state, so they read 0 after reset.
- Grant latency: a request visible in IDLE at edge t gives sd_rd/sd_wr = 1 after edge t, and busy = 1 after the same edge.
- sd_rd/sd_wr go low the cycle after sd_ack is first sampled high.
- Return to IDLE the cycle after sd_ack falls. The next grant can assert sd_rd one cycle later, so there are at least 2 idle cycles between transfers.
- Same-cycle events:
  - A new request arriving while sd_ack falls waits for IDLE.
  - A requester that re-asserts rd on the ack-fall cycle is lowest priority for the next pick.
- Reset mid-transfer: go to IDLE immediately and drop the strobes. No new grant is issued until sd_ack is low.
- sd_buff_din has zero added latency beyond the mux. The host samples it per its own protocol.

## Structure
- Package sd_arb_pkg:
  - state enum {IDLE, REQ, XFER}.
  - Block size constant 512.
  - MAX_PORTS = 4.
- Sub-module rr_pick: combinational round-robin priority encoder.
  - Inputs: req[PORTS], last[IW].
  - Outputs: valid, idx.
- Everything else lives in one always_ff plus output muxes.

## Test plan
- Single read: port 0 asserts rd with lba 0x15.
  - Expect sd_rd = 1 the next cycle with sd_lba = 0x15.
  - sd_ack high for 512 beats: only req_ack[0] and req_buff_wr[0] are active.
  - After ack falls: busy = 0.
- Contention: ports 0 and 1 request at the same cycle.
  - Expect grant order 0, 1, 0, 1 across four back-to-back re-requests.
- Write: port 1 asserts wr with lba 0x200 while port 0 is idle.
  - Expect sd_wr = 1, sd_buff_din to follow req_buff_din[1], and sd_rd to stay 0.
- rd and wr both set on port 0.
  - Expect the read transfer first.
  - Then a second grant with sd_wr for the same port.
- Reset mid-XFER with sd_ack still high and port 1 requesting.
  - Expect strobes 0 and no grant until sd_ack drops.
  - Then port 0 priority is restored (port 1 is granted because it is the only requester).
- Withdraw in REQ: port 0 drops rd before sd_ack.
  - Expect the transfer still to complete and no spurious second sd_rd.
